spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronised sclk/mosi/cs_n sampled on clk, back-to-back words under one cs_n.
// Define SPI_SLAVE_OVR_EN to build the sticky overrun flag; otherwise ovr is tied low.
module spi_slave #(
    parameter int WIDTH       = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_dat,
    output logic [WIDTH-1:0] rx_dat,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             busy,
    output logic             frame_err,
    output logic             ovr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, cs_sync_reg, live_reg;
    logic sclk_prev_reg, cs_prev_reg, armed_reg;
    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] tx_sh_reg, tx_sh_next;
    logic [WIDTH-2:0] rx_sh_reg, rx_sh_next;
    logic [WIDTH-1:0] rx_dat_reg, rx_dat_next;
    logic [WIDTH-1:0] rx_word;
    logic rx_valid_reg, rx_valid_next;
    logic frame_err_reg, frame_err_next;
    logic miso_reg, miso_next;
    logic pend_reg, pend_next;
    logic word_done;

    // live_reg fills with ones after reset so the armed flag only trusts cs_n
    // samples that actually came from the pin, not the reset preload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_sync_reg   <= '1;
            live_reg      <= '0;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
            armed_reg     <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
            live_reg      <= {live_reg[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
            if (live_reg[SYNC_STAGES-1] && cs_s)
                armed_reg <= 1'b1;
        end
    end

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign cs_fall   = armed_reg & cs_prev_reg & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_reg;
    assign rx_word   = {rx_sh_reg, mosi_s};

`ifdef SPI_SLAVE_OVR_EN
    logic ovr_reg, ovr_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            tx_sh_reg     <= '0;
            rx_sh_reg     <= '0;
            rx_dat_reg    <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            miso_reg      <= 1'b0;
            pend_reg      <= 1'b0;
`ifdef SPI_SLAVE_OVR_EN
            ovr_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            tx_sh_reg     <= tx_sh_next;
            rx_sh_reg     <= rx_sh_next;
            rx_dat_reg    <= rx_dat_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
            miso_reg      <= miso_next;
            pend_reg      <= pend_next;
`ifdef SPI_SLAVE_OVR_EN
            ovr_reg       <= ovr_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        tx_sh_next     = tx_sh_reg;
        rx_sh_next     = rx_sh_reg;
        rx_dat_next    = rx_dat_reg;
        rx_valid_next  = rx_valid_reg;
        frame_err_next = 1'b0;
        miso_next      = miso_reg;
        pend_next      = pend_reg;
        word_done      = 1'b0;

        if (rx_ack)
            rx_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                miso_next = 1'b0;
                if (cs_fall) begin
                    state_next = SHIFT;
                    tx_sh_next = tx_dat;
                    miso_next  = tx_dat[WIDTH-1];
                    cnt_next   = '0;
                    pend_next  = 1'b0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    miso_next  = 1'b0;
                    pend_next  = 1'b0;
                    if (cnt_reg != '0)
                        frame_err_next = 1'b1;
                end else if (sclk_rise) begin
                    rx_sh_next = rx_word[WIDTH-2:0];
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        // The reloaded MSB is held back until the next sclk fall
                        // so the last bit of this word stays on miso until then.
                        cnt_next      = '0;
                        rx_dat_next   = rx_word;
                        rx_valid_next = 1'b1;
                        tx_sh_next    = tx_dat;
                        pend_next     = 1'b1;
                        word_done     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (pend_reg) begin
                        miso_next = tx_sh_reg[WIDTH-1];
                        pend_next = 1'b0;
                    end else begin
                        tx_sh_next = tx_sh_reg << 1;
                        miso_next  = tx_sh_reg[WIDTH-2];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SPI_SLAVE_OVR_EN
    always_comb begin
        ovr_next = ovr_reg;
        if (word_done && rx_valid_reg && !rx_ack)
            ovr_next = 1'b1;
    end
    assign ovr = ovr_reg;
`else
    assign ovr = 1'b0;
`endif

    assign miso      = miso_reg;
    assign rx_dat    = rx_dat_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (WIDTH=13, SYNC_STAGES=2, sclk period = 20 clk periods).
// Overrun expectations follow SPI_SLAVE_OVR_EN when it is defined for the build.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [12:0] tx_dat = '0;
    logic [12:0] rx_dat;
    logic        rx_valid;
    logic        rx_ack = 1'b0;
    logic        busy;
    logic        frame_err;
    logic        ovr;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int lat = -1;
    logic ovr_exp;

    spi_slave #(.WIDTH(13), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_dat(tx_dat), .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .busy(busy), .frame_err(frame_err), .ovr(ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (frame_err === 1'b1) fe_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: 10 clk low, rise (slave samples mosi, master samples miso), 10 clk high.
    task automatic send_bits(input logic [12:0] mo, input int n, output logic [12:0] mi);
        mi = '0;
        lat = -1;
        for (int i = 0; i < n; i++) begin
            mosi = mo[12-i];
            tick(10);
            sclk = 1'b1;
            mi[12-i] = miso;
            for (int k = 1; k <= 10; k++) begin
                tick(1);
                if (i == n - 1 && lat < 0 && rx_valid === 1'b1) lat = k;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++; if (rx_dat !== 13'h0) begin n_bad++; $display("FAIL reset_rx_dat got %h want 0000", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", miso); end
        n_cmp++; if ({frame_err, ovr} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {frame_err, ovr}); end
        rst = 1'b1;
        tick(5);
        $display("reset: released");
    endtask

    task automatic test_basic();
        logic [12:0] mi;
        int fe0;
        fe0 = fe_cnt;
        tx_dat = 13'b0101001011001;
        cs_n = 1'b0;
        tick(10);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
        send_bits(13'b1001001001001, 13, mi);
        n_cmp++; if (rx_dat !== 13'b1001001001001) begin n_bad++; $display("FAIL basic_rx_dat got %b want 1001001001001", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rx_valid got %b want 1", rx_valid); end
        n_cmp++; if (mi !== 13'b0101001011001) begin n_bad++; $display("FAIL basic_miso_word got %b want 0101001011001", mi); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL basic_latency got %0d want 3", lat); end
        tick(10);
        cs_n = 1'b1;
        tick(10);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end got %b want 0", busy); end
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL basic_no_frame_err got %0d want 0", fe_cnt - fe0); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_hold got %b want 1", rx_valid); end
        ack_pulse();
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack got %b want 0", rx_valid); end
        $display("basic: rx=%b miso_word=%b latency=%0d", rx_dat, mi, lat);
    endtask

    task automatic test_idle_ignore();
        mosi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; tick(5);
            sclk = 1'b0; tick(5);
        end
        mosi = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
        n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL idle_miso got %b want 0", miso); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rx_valid got %b want 0", rx_valid); end
        n_cmp++; if (rx_dat !== 13'b1001001001001) begin n_bad++; $display("FAIL idle_rx_dat got %b want 1001001001001", rx_dat); end
        $display("idle: sclk toggles ignored, busy=%b", busy);
    endtask

    task automatic test_back_to_back();
        logic [12:0] mi1, mi2;
        int fe0;
        fe0 = fe_cnt;
        tx_dat = 13'h0F0F;
        cs_n = 1'b0;
        tick(5);
        tx_dat = 13'h1234;
        tick(5);
        send_bits(13'h0AAA, 13, mi1);
        n_cmp++; if (rx_dat !== 13'h0AAA) begin n_bad++; $display("FAIL b2b_rx1 got %h want 0aaa", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid1 got %b want 1", rx_valid); end
        n_cmp++; if (mi1 !== 13'h0F0F) begin n_bad++; $display("FAIL b2b_miso1 got %h want 0f0f", mi1); end
        ack_pulse();
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ack1 got %b want 0", rx_valid); end
        send_bits(13'h1555, 13, mi2);
        n_cmp++; if (rx_dat !== 13'h1555) begin n_bad++; $display("FAIL b2b_rx2 got %h want 1555", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid2 got %b want 1", rx_valid); end
        n_cmp++; if (mi2 !== 13'h1234) begin n_bad++; $display("FAIL b2b_miso2 got %h want 1234", mi2); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", busy); end
        ack_pulse();
        tick(10);
        cs_n = 1'b1;
        tick(10);
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL b2b_no_frame_err got %0d want 0", fe_cnt - fe0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end got %b want 0", busy); end
        $display("back_to_back: miso words %h %h", mi1, mi2);
    endtask

    task automatic test_frame_err();
        logic [12:0] mi;
        int fe0;
        cs_n = 1'b0;
        tick(10);
        send_bits(13'h1FFF, 5, mi);
        tick(10);
        fe0 = fe_cnt;
        cs_n = 1'b1;
        tick(10);
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (rx_dat !== 13'h1555) begin n_bad++; $display("FAIL ferr_rx_dat got %h want 1555", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ferr_rx_valid got %b want 0", rx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy got %b want 0", busy); end
        $display("frame_err: pulses=%0d", fe_cnt - fe0);
    endtask

    task automatic test_overrun();
        logic [12:0] mi;
`ifdef SPI_SLAVE_OVR_EN
        ovr_exp = 1'b1;
`else
        ovr_exp = 1'b0;
`endif
        tx_dat = 13'h0000;
        cs_n = 1'b0;
        tick(10);
        send_bits(13'h0123, 13, mi);
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_first got %b want 0", ovr); end
        send_bits(13'h1ABC, 13, mi);
        n_cmp++; if (rx_dat !== 13'h1ABC) begin n_bad++; $display("FAIL ovr_rx_dat got %h want 1abc", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_rx_valid got %b want 1", rx_valid); end
        n_cmp++; if (ovr !== ovr_exp) begin n_bad++; $display("FAIL ovr_flag got %b want %b", ovr, ovr_exp); end
        tick(10);
        cs_n = 1'b1;
        tick(10);
        ack_pulse();
        tick(2);
        n_cmp++; if (ovr !== ovr_exp) begin n_bad++; $display("FAIL ovr_sticky got %b want %b", ovr, ovr_exp); end
        $display("overrun: ovr=%b rx=%h", ovr, rx_dat);
    endtask

    task automatic test_reset_midframe();
        logic [12:0] mi;
        tx_dat = 13'h1F0F;
        cs_n = 1'b0;
        tick(10);
        send_bits(13'h1FFF, 7, mi);
        rst = 1'b0;
        #1;
        n_cmp++; if (rx_dat !== 13'h0) begin n_bad++; $display("FAIL rstmid_rx_dat got %h want 0000", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_rx_valid got %b want 0", rx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if ({miso, frame_err, ovr} !== 3'b000) begin n_bad++; $display("FAIL rstmid_bits got %b want 000", {miso, frame_err, ovr}); end
        tick(3);
        rst = 1'b1;
        tick(15);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_start got %b want 0", busy); end
        cs_n = 1'b1;
        tick(10);
        cs_n = 1'b0;
        tick(10);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart got %b want 1", busy); end
        send_bits(13'h0B6D, 13, mi);
        n_cmp++; if (rx_dat !== 13'h0B6D) begin n_bad++; $display("FAIL rstmid_rx got %h want 0b6d", rx_dat); end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid got %b want 1", rx_valid); end
        n_cmp++; if (mi !== 13'h1F0F) begin n_bad++; $display("FAIL rstmid_miso got %h want 1f0f", mi); end
        tick(10);
        cs_n = 1'b1;
        tick(10);
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovr got %b want 0", ovr); end
        $display("reset_midframe: rx=%h miso_word=%h", rx_dat, mi);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_ignore();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
